// File: rtl/pc_gen.sv
// Fetch-PC generator: picks the next PC from exception vector, ERET, branch, jump or PC+4,
// keeps the EPC and buffers one redirect that arrives while fetch is stalled.
module pc_gen #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = 32'h0000_3000,
  parameter logic [WIDTH-1:0]   EXC_VEC  = 32'h0000_4180
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             pending,
  output logic             adel
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic [0:0]       state_q, state_d;

  logic             redir;
  logic [WIDTH-1:0] redir_target;

  assign redir        = br_taken | jump;
  assign redir_target = br_taken ? br_target : jump_target;

  assign pc_plus4 = pc_q + WIDTH'(4);
  assign pc       = pc_q;
  assign epc      = epc_q;
  assign pending  = (state_q == ST_PEND);
  assign adel     = (pc_q[1:0] != 2'b00);

  always_comb begin
    pc_d          = pc_q;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
    state_d       = state_q;
    if (exc_req) begin
      pc_d    = EXC_VEC;
      epc_d   = exc_epc;
      state_d = ST_RUN;
    end else if (eret) begin
      pc_d    = epc_q;
      state_d = ST_RUN;
    end else if (state_q == ST_PEND) begin
      // Redirects seen while releasing the buffered one are on the wrong path.
      if (en) begin
        pc_d    = pend_target_q;
        state_d = ST_RUN;
      end else if (redir) begin
        pend_target_d = redir_target;
      end
    end else if (en) begin
      pc_d = redir ? redir_target : pc_plus4;
    end else if (redir) begin
      pend_target_d = redir_target;
      state_d       = ST_PEND;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      epc_q         <= '0;
      pend_target_q <= '0;
      state_q       <= ST_RUN;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_target_q <= pend_target_d;
      state_q       <= state_d;
    end
  end

endmodule
